// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator.
//
// Divides the board clock down to the pixel rate. Runs the horizontal and
// vertical counters and produces the sync pulses and the VIDON/HC/VC set
// used by the colour generator. Display start and stop happen only at frame
// boundaries, so a frame is never cut short.
//
// Ports
//   clk          board clock
//   rst          asynchronous, active-high reset
//   en           run enable; start/stop requests take effect at frame edges
//   HC, VC       pixel / line coordinate, 0/0 = first visible pixel
//   VIDON        high inside the visible window while running
//   hsync, vsync active-low sync pulses
//   pix_tick     one-clk pulse per pixel period
//   frame_start  one-clk pulse when HC/VC enter 0/0 on a running frame
//   running      high while frames are being produced (RUN or DRAIN)
//
// Every output is registered. The next-state values are computed
// combinationally and the outputs are derived from those next-state values.
// As a result HC, VC, VIDON and the syncs always change on the same edge.

module vga_timing_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] HC,
    output logic [9:0] VC,
    output logic       VIDON,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_tick,
    output logic       frame_start,
    output logic       running
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOT - 1);

    // These bounds use 11 bits because a sync end can sit exactly at 1024.
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYN_LO = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYN_HI = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYN_LO = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYN_HI = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // The counters are 10 bits wide, so neither total may exceed 1024.
    if (CLK_DIV < 1 || H_TOT > 1024 || V_TOT > 1024) begin : g_param_check
        $error("vga_timing_ctrl: CLK_DIV must be >= 1 and H_TOT/V_TOT <= 1024");
    end

    logic [1:0]       state, state_nxt;
    logic [DIV_W-1:0] div, div_nxt;
    logic [9:0]       hc_nxt, vc_nxt;
    logic             tick_nxt;
    logic             fs_nxt;
    logic             div_wrap;
    logic             at_end;
    logic             active_nxt;

    // NOTE: every signal gets a default at the top of the block. Without a
    // default, a path through the case would leave a signal unassigned, and
    // synthesis would infer a latch.
    always_comb begin
        state_nxt = state;
        div_nxt   = '0;
        hc_nxt    = HC;
        vc_nxt    = VC;
        tick_nxt  = 1'b0;
        fs_nxt    = 1'b0;
        div_wrap  = (div == DIV_LAST);
        at_end    = (HC == H_LAST) && (VC == V_LAST);

        case (state)
            ST_IDLE: begin
                hc_nxt = '0;
                vc_nxt = '0;
                // The first pixel starts on the entry edge itself, so the
                // start latency from en is one clock.
                if (en) begin
                    state_nxt = ST_RUN;
                    tick_nxt  = 1'b1;
                    fs_nxt    = 1'b1;
                end
            end

            ST_RUN, ST_DRAIN: begin
                div_nxt   = div_wrap ? '0 : div + 1'b1;
                tick_nxt  = div_wrap;
                state_nxt = en ? ST_RUN : ST_DRAIN;
                if (div_wrap) begin
                    if (HC == H_LAST) begin
                        hc_nxt = '0;
                        vc_nxt = (VC == V_LAST) ? '0 : VC + 1'b1;
                    end else begin
                        hc_nxt = HC + 1'b1;
                    end
                    if (at_end) begin
                        // The stop decision is taken only here, at the frame
                        // boundary. A stop request that has been withdrawn
                        // (en high again) simply keeps the frame going.
                        if (state == ST_DRAIN && !en) begin
                            state_nxt = ST_IDLE;
                            tick_nxt  = 1'b0;
                        end else begin
                            fs_nxt = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                hc_nxt    = '0;
                vc_nxt    = '0;
            end
        endcase

        active_nxt = (state_nxt != ST_IDLE);
    end

    // NOTE: state registers use non-blocking assignments. All flops then
    // sample their inputs at the same edge, whatever order the statements
    // appear in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            div         <= '0;
            HC          <= '0;
            VC          <= '0;
            VIDON       <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            pix_tick    <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_nxt;
            div         <= div_nxt;
            HC          <= hc_nxt;
            VC          <= vc_nxt;
            VIDON       <= active_nxt && ({1'b0, hc_nxt} < H_VIS) && ({1'b0, vc_nxt} < V_VIS);
            hsync       <= !(active_nxt && ({1'b0, hc_nxt} >= H_SYN_LO) && ({1'b0, hc_nxt} < H_SYN_HI));
            vsync       <= !(active_nxt && ({1'b0, vc_nxt} >= V_SYN_LO) && ({1'b0, vc_nxt} < V_SYN_HI));
            pix_tick    <= tick_nxt;
            frame_start <= fs_nxt;
            running     <= active_nxt;
        end
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Generates VGA raster timing: pixel-rate tick, horizontal/vertical counters, sync pulses and the VIDON / HC / VC coordinate set consumed by color_gen.
- Sits between the board clock and the color generator.
- Supports start/stop at frame boundaries under a run-enable, so higher-level logic can halt the display cleanly.

Parameters:
- CLK_DIV, 2, board clocks per pixel (≥1); 50 MHz → 25 MHz pixel rate
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  board clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; sampled per Behaviour
- HC  out  10  horizontal count; 0..H_TOT-1, 0 = first visible pixel
- VC  out  10  vertical count; 0..V_TOT-1, 0 = first visible line
- VIDON  out  1  high when HC<H_ACTIVE and VC<V_ACTIVE and state=RUN/DRAIN
- hsync  out  1  active-low; low when H_ACTIVE+H_FP ≤ HC < H_ACTIVE+H_FP+H_SYNC
- vsync  out  1  active-low; low when V_ACTIVE+V_FP ≤ VC < V_ACTIVE+V_FP+V_SYNC
- pix_tick  out  1  one-clk pulse per pixel period
- frame_start  out  1  one-clk pulse coincident with pix_tick when HC/VC enter 0/0
- running  out  1  high in RUN or DRAIN

Behaviour:
- Totals: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP (525). All outputs are registered; there is no combinational path from en to any output.
- Reset (async, any time): state=IDLE; divider=0; HC=0, VC=0, VIDON=0, hsync=1, vsync=1, pix_tick=0, frame_start=0, running=0. Deassertion is sampled on the next clk edge; there is no partial-frame carry-over.
- Divider: counts 0..CLK_DIV-1 only in RUN/DRAIN. pix_tick=1 on the clk where the divider wraps to 0. With CLK_DIV=1, pix_tick is constantly high in RUN/DRAIN. The divider is held at 0 in IDLE.
- Counters, on pix_tick only:
  - HC increments.
  - At HC=H_TOT-1, HC→0 and VC increments.
  - At VC=V_TOT-1 with HC=H_TOT-1, VC→0.
  - HC/VC/VIDON/hsync/vsync update on the same edge, so they are mutually consistent every cycle.
- State machine:
  - IDLE: outputs as reset. en=1 → RUN on the next clk. On that entry edge, HC=VC=0, VIDON=1, frame_start=1 and pix_tick=1: the first pixel starts immediately, latency 1 clk from en.
  - RUN: normal counting. en=0 → DRAIN; counting continues uninterrupted.
  - DRAIN: counting continues. en=1 → RUN with no disturbance. On the pix_tick where HC=H_TOT-1 and VC=V_TOT-1, the state goes to IDLE instead of wrapping: HC=VC=0, VIDON=0, frame_start not pulsed.
  - A frame is never truncated by en.
- frame_start: pulses on IDLE→RUN entry and on every wrap to 0/0 in RUN. It is not pulsed on the DRAIN→IDLE transition.
- Widths: counters are 10 bits. H_TOT and V_TOT must be ≤1024; this is checked by an elaboration-time assertion.
- Simultaneous events: en toggling 1→0→1 within one frame leaves timing unaffected. Reset asserted mid-line takes priority over everything and forces the reset values within the same cycle (async).

Test Plan:
- Reset/idle: rst=1 for 3 clks, en=0 for 20 clks → HC=VC=0, VIDON=0, hsync=vsync=1, pix_tick=0, running=0 throughout.
- Start and line timing: en=1 at clk N → at N+1: running=1, frame_start=1, VIDON=1, HC=0. With CLK_DIV=2:
  - HC=639 at N+1279; VIDON falls with HC=640 at N+1281.
  - hsync low for HC 656..751 (192 clks).
  - HC wraps to 0 with VC=1 at N+1601.
- Frame timing: run 2 full frames → vsync low exactly for VC 490..491 (1600 pixels). frame_start pulses exactly once per 420000 pixels at HC=VC=0. VIDON-high count per frame = 307200 pixels.
- Drain: drop en at VC=100 → counting continues through VC=524/HC=799, then IDLE with HC=VC=0, VIDON=0, running=0. No frame_start pulse at that boundary.
- Re-enable in DRAIN: en 1→0 at VC=200, back to 1 at VC=300 → frame continues without a glitch and wraps to VC=0 with frame_start=1. State stays running.
- Async reset mid-frame: assert rst between clk edges at HC=320, VC=240 → all outputs at reset values before the next edge. After release with en=1, restart per the start scenario. Repeat the start scenario with CLK_DIV=1: pix_tick continuously high.
